// File: rtl/rr_mux8_arbiter_if.sv
// Request/grant/select bundle between the eight requesters and the 8:1 mux arbiter.
// The arbiter takes the slave side; the requester side (or bench) takes master.
interface rr_mux8_arbiter_if;
   logic [7:0] req;
   logic [7:0] gnt;
   logic       S1;
   logic       S2;
   logic       S3;
   logic       valid;

   modport master (output req, input gnt, input S1, input S2, input S3, input valid);
   modport slave  (input req, output gnt, output S1, output S2, output S3, output valid);
endinterface

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter for the shared 8:1 mux: one-hot grant, registered select
// lines and a bounded hold time whenever other requesters are waiting.
module rr_mux8_arbiter #(
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              rst,
   rr_mux8_arbiter_if.slave  bus
);

   localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state;
   logic [7:0] gnt_r;
   logic [2:0] sel_r;
   logic [2:0] lptr;
   logic       vld_r;
   logic [3:0] hold_cnt;

   logic [7:0] others;
   logic       own_req;
   logic [3:0] pick_req;
   logic [3:0] pick_oth;

   // Returns {found, index} of the first set bit scanning p+1, p+2, ... modulo 8.
   function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'b0;
      for (int i = 8; i >= 1; i--) begin
         idx = p + 3'(i);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   always_comb begin
      others   = bus.req & ~gnt_r;
      own_req  = |(bus.req & gnt_r);
      pick_req = rr_pick(bus.req, lptr);
      pick_oth = rr_pick(others, lptr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt_r    <= 8'h00;
         sel_r    <= 3'd0;
         vld_r    <= 1'b0;
         lptr     <= 3'd7;
         hold_cnt <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_req[3]) begin
                  gnt_r    <= 8'(1) << pick_req[2:0];
                  sel_r    <= pick_req[2:0];
                  lptr     <= pick_req[2:0];
                  vld_r    <= 1'b1;
                  hold_cnt <= 4'd1;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               // lptr always names the current owner while in GRANT.
               if ((!own_req || hold_cnt >= HOLD_LIM) && pick_oth[3]) begin
                  gnt_r    <= 8'(1) << pick_oth[2:0];
                  sel_r    <= pick_oth[2:0];
                  lptr     <= pick_oth[2:0];
                  hold_cnt <= 4'd1;
               end else if (!own_req) begin
                  gnt_r <= 8'h00;
                  vld_r <= 1'b0;
                  state <= IDLE;
               end else if (hold_cnt < HOLD_LIM) begin
                  hold_cnt <= hold_cnt + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.gnt   = gnt_r;
   assign bus.S1    = sel_r[0];
   assign bus.S2    = sel_r[1];
   assign bus.S3    = sel_r[2];
   assign bus.valid = vld_r;

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Directed bench for rr_mux8_arbiter (MAX_HOLD=4): a cycle table plus
// hand-written rotation, saturation and reset-during-grant sequences.
module tb_rr_mux8_arbiter;

   logic clk;
   logic rst;
   int   checks;
   int   passes;

   rr_mux8_arbiter_if bus ();

   rr_mux8_arbiter #(.MAX_HOLD(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic [7:0] gnt;
      logic [2:0] sel;
      logic       vld;
   } vec_t;

   vec_t tbl [19];

   task automatic step(input logic r, input logic [7:0] rq);
      @(negedge clk);
      rst     = r;
      bus.req = rq;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] eg, input logic [2:0] es,
                        input logic ev);
      logic [2:0] s;
      s = {bus.S3, bus.S2, bus.S1};
      checks++;
      if (bus.gnt === eg && s === es && bus.valid === ev) passes++;
      else $display("FAIL %s: got gnt=%h sel=%0d valid=%b, required gnt=%h sel=%0d valid=%b",
                    name, bus.gnt, s, bus.valid, eg, es, ev);
      checks++;
      if ($onehot0(bus.gnt) && (bus.valid === |bus.gnt)) passes++;
      else $display("FAIL %s_invariant: got gnt=%h valid=%b, required one-hot-or-zero gnt with valid=|gnt",
                    name, bus.gnt, bus.valid);
   endtask

   initial begin
      checks  = 0;
      passes  = 0;
      rst     = 1'b1;
      bus.req = 8'h00;

      tbl[0]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0};
      tbl[1]  = '{1'b0, 8'h01, 8'h01, 3'd0, 1'b1};
      tbl[2]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0};
      tbl[3]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0};
      tbl[4]  = '{1'b0, 8'h20, 8'h20, 3'd5, 1'b1};
      tbl[5]  = '{1'b0, 8'h60, 8'h20, 3'd5, 1'b1};
      tbl[6]  = '{1'b0, 8'h60, 8'h20, 3'd5, 1'b1};
      tbl[7]  = '{1'b0, 8'h60, 8'h20, 3'd5, 1'b1};
      tbl[8]  = '{1'b0, 8'h60, 8'h40, 3'd6, 1'b1};
      tbl[9]  = '{1'b0, 8'h00, 8'h00, 3'd6, 1'b0};
      tbl[10] = '{1'b0, 8'h00, 8'h00, 3'd6, 1'b0};
      tbl[11] = '{1'b0, 8'h81, 8'h80, 3'd7, 1'b1};
      tbl[12] = '{1'b0, 8'h05, 8'h01, 3'd0, 1'b1};
      tbl[13] = '{1'b0, 8'h04, 8'h04, 3'd2, 1'b1};
      tbl[14] = '{1'b1, 8'h20, 8'h00, 3'd0, 1'b0};
      tbl[15] = '{1'b0, 8'h20, 8'h20, 3'd5, 1'b1};
      tbl[16] = '{1'b0, 8'h60, 8'h20, 3'd5, 1'b1};
      tbl[17] = '{1'b0, 8'h40, 8'h40, 3'd6, 1'b1};
      tbl[18] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0};

      for (int i = 0; i < 19; i++) begin
         step(tbl[i].rst, tbl[i].req);
         check($sformatf("tbl%0d", i), tbl[i].gnt, tbl[i].sel, tbl[i].vld);
      end

      // All eight requesting: four cycles each, wrapping 7 -> 0.
      step(1'b1, 8'hFF);
      check("rot_reset", 8'h00, 3'd0, 1'b0);
      for (int g = 0; g < 9; g++) begin
         for (int c = 0; c < 4; c++) begin
            step(1'b0, 8'hFF);
            check($sformatf("rot_g%0d_c%0d", g, c), 8'(1) << (g % 8), 3'(g % 8), 1'b1);
         end
      end

      // Lone requester holds past the limit, then yields at once to a newcomer.
      step(1'b1, 8'h00);
      for (int c = 0; c < 20; c++) begin
         step(1'b0, 8'h08);
         check($sformatf("solo3_c%0d", c), 8'h08, 3'd3, 1'b1);
      end
      step(1'b0, 8'h0A);
      check("solo3_yield", 8'h02, 3'd1, 1'b1);

      // Reset in the middle of a grant.
      step(1'b1, 8'h00);
      step(1'b0, 8'h04);
      check("mid_grant2", 8'h04, 3'd2, 1'b1);
      step(1'b0, 8'hFF);
      check("mid_hold2", 8'h04, 3'd2, 1'b1);
      step(1'b1, 8'hFF);
      check("mid_rst", 8'h00, 3'd0, 1'b0);
      step(1'b0, 8'hFF);
      check("mid_after", 8'h01, 3'd0, 1'b1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
